// File: rtl/game_sequencer.sv
// Play controller for the game plate: turns button pulses and a gravity
// timer into a strictly serialised opcode stream, follows each landing with
// Commit/Check/New, and keeps the cleared-line total and game-over status.

package game_sequencer_pkg;
    typedef enum logic [2:0] {
        eNop       = 3'd0,
        eNew       = 3'd1,
        eMoveLeft  = 3'd2,
        eMoveRight = 3'd3,
        eMoveDown  = 3'd4,
        eRotate    = 3'd5,
        eCommit    = 3'd6,
        eCheck     = 3'd7
    } opcode_e;
endpackage

module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int height_p         = 32,
    parameter int gravity_period_p = 50000000,
    parameter int gap_p            = 2
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        start_i,
    input  logic                        pause_i,
    input  logic                        btn_left_i,
    input  logic                        btn_right_i,
    input  logic                        btn_rotate_i,
    input  logic                        btn_drop_i,
    output opcode_e                     opcode_o,
    output logic                        opcode_v_o,
    input  logic                        done_i,
    input  logic                        land_i,
    input  logic                        lose_i,
    input  logic [$clog2(height_p)-1:0] lines_i,
    input  logic                        lines_v_i,
    output logic [15:0]                 lines_total_o,
    output logic                        playing_o,
    output logic                        game_over_o
);

    localparam int lines_w_lp = $clog2(height_p);
    localparam int grav_w_lp  = $clog2(gravity_period_p);
    localparam int gap_w_lp   = $clog2(gap_p + 1);

    localparam logic [grav_w_lp-1:0] grav_last_lp = grav_w_lp'(gravity_period_p - 1);
    localparam logic [gap_w_lp-1:0]  gap_last_lp  = gap_w_lp'(gap_p - 1);

    localparam logic [2:0] st_idle  = 3'd0;
    localparam logic [2:0] st_issue = 3'd1;
    localparam logic [2:0] st_wait  = 3'd2;
    localparam logic [2:0] st_gap   = 3'd3;
    localparam logic [2:0] st_play  = 3'd4;
    localparam logic [2:0] st_over  = 3'd5;

    logic [2:0]           state_r;
    opcode_e              op_r;
    logic                 opcode_v_r;
    logic                 playing_r;
    logic                 game_over_r;
    logic                 land_r;
    logic                 from_drop_r;
    logic [gap_w_lp-1:0]  gap_cnt_r;
    logic [grav_w_lp-1:0] grav_cnt_r;
    logic [15:0]          lines_total_r;
    logic                 pend_left_r;
    logic                 pend_right_r;
    logic                 pend_rot_r;
    logic                 pend_drop_r;
    logic                 pend_grav_r;

    logic [2:0]           state_n_s;
    opcode_e              op_n_s;
    logic                 from_drop_n_s;
    logic                 start_s;
    logic                 playing_s;
    logic                 grav_wrap_s;
    logic                 refire_drop_s;
    logic                 clr_left_s;
    logic                 clr_right_s;
    logic                 clr_rot_s;
    logic                 clr_drop_s;
    logic                 clr_grav_s;
    logic                 any_pend_s;
    logic [16:0]          lines_sum_s;

    assign opcode_o      = op_r;
    assign opcode_v_o    = opcode_v_r;
    assign lines_total_o = lines_total_r;
    assign playing_o     = playing_r;
    assign game_over_o   = game_over_r;

    assign playing_s   = (state_r != st_idle) && (state_r != st_over);
    assign any_pend_s  = pend_drop_r | pend_grav_r | pend_rot_r | pend_left_r | pend_right_r;
    assign grav_wrap_s = (state_r == st_play) && !pause_i && (grav_cnt_r == grav_last_lp);
    assign lines_sum_s = {1'b0, lines_total_r} + {{(17 - lines_w_lp){1'b0}}, lines_i};

    // Next-state decode: request arbitration in PLAY and post-op follow-up in GAP.
    always_comb begin
        state_n_s     = state_r;
        op_n_s        = op_r;
        from_drop_n_s = from_drop_r;
        start_s       = 1'b0;
        refire_drop_s = 1'b0;
        clr_left_s    = 1'b0;
        clr_right_s   = 1'b0;
        clr_rot_s     = 1'b0;
        clr_drop_s    = 1'b0;
        clr_grav_s    = 1'b0;
        case (state_r)
            st_idle, st_over: begin
                if (start_i) begin
                    start_s   = 1'b1;
                    state_n_s = st_issue;
                    op_n_s    = eNew;
                end else begin
                    state_n_s = state_r;
                end
            end
            st_play: begin
                if (!pause_i && any_pend_s) begin
                    state_n_s = st_issue;
                    if (pend_drop_r) begin
                        op_n_s        = eMoveDown;
                        clr_drop_s    = 1'b1;
                        from_drop_n_s = 1'b1;
                    end else if (pend_grav_r) begin
                        op_n_s        = eMoveDown;
                        clr_grav_s    = 1'b1;
                        from_drop_n_s = 1'b0;
                    end else if (pend_rot_r) begin
                        op_n_s    = eRotate;
                        clr_rot_s = 1'b1;
                    end else if (pend_left_r) begin
                        op_n_s     = eMoveLeft;
                        clr_left_s = 1'b1;
                    end else begin
                        op_n_s      = eMoveRight;
                        clr_right_s = 1'b1;
                    end
                end else begin
                    state_n_s = st_play;
                end
            end
            st_issue: begin
                state_n_s = st_wait;
            end
            st_wait: begin
                if (done_i) begin
                    state_n_s = st_gap;
                end else begin
                    state_n_s = st_wait;
                end
            end
            st_gap: begin
                if (gap_cnt_r == gap_last_lp) begin
                    if (lose_i) begin
                        state_n_s = st_over;
                    end else if (op_r == eNew) begin
                        state_n_s = st_play;
                    end else if ((op_r == eMoveDown) && land_r) begin
                        state_n_s  = st_issue;
                        op_n_s     = eCommit;
                        clr_drop_s = 1'b1;
                    end else if ((op_r == eMoveDown) && from_drop_r) begin
                        // Hard drop keeps stepping down until the tile lands.
                        refire_drop_s = 1'b1;
                        state_n_s     = st_play;
                    end else if (op_r == eCommit) begin
                        state_n_s = st_issue;
                        op_n_s    = eCheck;
                    end else if (op_r == eCheck) begin
                        state_n_s = st_issue;
                        op_n_s    = eNew;
                    end else begin
                        state_n_s = st_play;
                    end
                end else begin
                    state_n_s = st_gap;
                end
            end
            default: begin
                state_n_s = st_idle;
            end
        endcase
    end

    // Control registers: state, opcode, one-cycle valid and status outputs.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= st_idle;
            op_r        <= eNop;
            opcode_v_r  <= 1'b0;
            playing_r   <= 1'b0;
            game_over_r <= 1'b0;
            land_r      <= 1'b0;
            from_drop_r <= 1'b0;
            gap_cnt_r   <= '0;
        end else begin
            state_r     <= state_n_s;
            op_r        <= op_n_s;
            opcode_v_r  <= (state_n_s == st_issue);
            playing_r   <= (state_n_s != st_idle) && (state_n_s != st_over);
            game_over_r <= (state_n_s == st_over);
            from_drop_r <= from_drop_n_s;
            if ((state_r == st_issue) && (op_r == eMoveDown)) begin
                land_r <= land_i;
            end
            if (state_r == st_wait) begin
                gap_cnt_r <= '0;
            end else if (state_r == st_gap) begin
                gap_cnt_r <= gap_cnt_r + gap_w_lp'(1);
            end
        end
    end

    // Sticky request flags: a new pulse wins over a same-cycle clear.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pend_left_r  <= 1'b0;
            pend_right_r <= 1'b0;
            pend_rot_r   <= 1'b0;
            pend_drop_r  <= 1'b0;
            pend_grav_r  <= 1'b0;
        end else if (start_s) begin
            pend_left_r  <= 1'b0;
            pend_right_r <= 1'b0;
            pend_rot_r   <= 1'b0;
            pend_drop_r  <= 1'b0;
            pend_grav_r  <= 1'b0;
        end else begin
            pend_left_r  <= (pend_left_r  & ~clr_left_s)  | (btn_left_i   & playing_s);
            pend_right_r <= (pend_right_r & ~clr_right_s) | (btn_right_i  & playing_s);
            pend_rot_r   <= (pend_rot_r   & ~clr_rot_s)   | (btn_rotate_i & playing_s);
            pend_drop_r  <= (pend_drop_r  & ~clr_drop_s)  | (btn_drop_i   & playing_s) | refire_drop_s;
            pend_grav_r  <= (pend_grav_r  & ~clr_grav_s)  | grav_wrap_s;
        end
    end

    // Gravity timer: advances only in unpaused PLAY, restarts with each new tile.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            grav_cnt_r <= '0;
        end else if ((state_r == st_issue) && (op_r == eNew)) begin
            grav_cnt_r <= '0;
        end else if ((state_r == st_play) && !pause_i) begin
            grav_cnt_r <= grav_wrap_s ? '0 : grav_cnt_r + grav_w_lp'(1);
        end
    end

    // Cleared-line accumulator, saturating at all ones.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            lines_total_r <= 16'h0000;
        end else if (start_s) begin
            lines_total_r <= 16'h0000;
        end else if (lines_v_i) begin
            lines_total_r <= lines_sum_s[16] ? 16'hFFFF : lines_sum_s[15:0];
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Randomised bench for game_sequencer: a plate responder answers each opcode,
// and a cycle-level reference model built from the play rules predicts every
// output on every cycle.

module tb_game_sequencer;
    import game_sequencer_pkg::*;

    localparam int grav_p = 8;
    localparam int gap_c  = 2;

    logic       clk_i = 1'b0;
    logic       reset_n_i;
    logic       start_i, pause_i;
    logic       btn_left_i, btn_right_i, btn_rotate_i, btn_drop_i;
    opcode_e    opcode_o;
    logic       opcode_v_o;
    logic       done_i, land_i, lose_i;
    logic [4:0] lines_i;
    logic       lines_v_i;
    logic [15:0] lines_total_o;
    logic       playing_o, game_over_o;

    game_sequencer #(.height_p(32), .gravity_period_p(grav_p), .gap_p(gap_c)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i), .pause_i(pause_i),
        .btn_left_i(btn_left_i), .btn_right_i(btn_right_i),
        .btn_rotate_i(btn_rotate_i), .btn_drop_i(btn_drop_i),
        .opcode_o(opcode_o), .opcode_v_o(opcode_v_o), .done_i(done_i),
        .land_i(land_i), .lose_i(lose_i), .lines_i(lines_i), .lines_v_i(lines_v_i),
        .lines_total_o(lines_total_o), .playing_o(playing_o), .game_over_o(game_over_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: "free to arbitrate" is derived, not stored.
    bit      m_run, m_over, m_fire, m_wait, m_land, m_src;
    int      m_cool, m_ticks, m_total;
    opcode_e m_op;
    bit      req[5];   // priority order: drop, grav, rot, left, right

    // Plate responder
    int      pl_cnt;
    opcode_e pl_op;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic opcode_e req_op(input int k);
        case (k)
            0, 1:    return eMoveDown;
            2:       return eRotate;
            3:       return eMoveLeft;
            default: return eMoveRight;
        endcase
    endfunction

    task automatic model_reset();
        m_run = 0; m_over = 0; m_fire = 0; m_wait = 0; m_land = 0; m_src = 0;
        m_cool = 0; m_ticks = 0; m_total = 0; m_op = eNop;
        for (int k = 0; k < 5; k++) req[k] = 0;
    endtask

    task automatic model_step();
        bit was_run, free, started, grav_set, refire;
        bit clr[5];
        bit btn[5];
        int pick;
        was_run  = m_run;
        free     = m_run && !m_fire && !m_wait && (m_cool == 0);
        started  = !m_run && start_i;
        grav_set = 0; refire = 0;
        for (int k = 0; k < 5; k++) clr[k] = 0;
        btn[0] = btn_drop_i; btn[1] = 0; btn[2] = btn_rotate_i;
        btn[3] = btn_left_i; btn[4] = btn_right_i;

        if (started) m_total = 0;
        else if (lines_v_i) m_total = (m_total + int'(lines_i) > 65535) ? 65535 : m_total + int'(lines_i);

        if (started) begin
            m_run = 1; m_over = 0; m_fire = 1; m_op = eNew;
            for (int k = 0; k < 5; k++) req[k] = 0;
        end else if (m_fire) begin
            m_fire = 0; m_wait = 1;
            if (m_op == eMoveDown) m_land = land_i;
            if (m_op == eNew) m_ticks = 0;
        end else if (m_wait) begin
            if (done_i) begin m_wait = 0; m_cool = gap_c; end
        end else if (m_cool > 0) begin
            m_cool--;
            if (m_cool == 0) begin
                if (lose_i) begin
                    m_run = 0; m_over = 1;
                end else if (m_op == eMoveDown && m_land) begin
                    m_fire = 1; m_op = eCommit; clr[0] = 1;
                end else if (m_op == eMoveDown && m_src) begin
                    refire = 1;
                end else if (m_op == eCommit) begin
                    m_fire = 1; m_op = eCheck;
                end else if (m_op == eCheck) begin
                    m_fire = 1; m_op = eNew;
                end
            end
        end else if (free && !pause_i) begin
            pick = -1;
            for (int k = 4; k >= 0; k--) if (req[k]) pick = k;
            if (pick >= 0) begin
                clr[pick] = 1; m_fire = 1; m_op = req_op(pick); m_src = (pick == 0);
            end
            m_ticks++;
            if (m_ticks == grav_p) begin m_ticks = 0; grav_set = 1; end
        end

        if (was_run) begin
            for (int k = 0; k < 5; k++) req[k] = (req[k] && !clr[k]) || btn[k];
            req[1] = req[1] || grav_set;
            req[0] = req[0] || refire;
        end
    endtask

    task automatic clear_inputs();
        start_i = 0; btn_left_i = 0; btn_right_i = 0; btn_rotate_i = 0; btn_drop_i = 0;
        done_i = 0; land_i = 0; lose_i = 0; lines_i = 5'd0; lines_v_i = 0;
    endtask

    task automatic run_cycle(input bit rnd, input bit st, input bit lv, input logic [4:0] lval);
        @(negedge clk_i);
        clear_inputs();
        if (rnd) begin
            if (pl_cnt > 0) begin
                pl_cnt--;
                if (pl_cnt == 0) begin
                    done_i = 1;
                    if (pl_op == eCheck) begin lines_v_i = 1; lines_i = 5'($urandom_range(0, 4)); end
                end
            end
            if (opcode_v_o) begin pl_cnt = $urandom_range(1, 4); pl_op = opcode_o; end
            if (!lines_v_i && $urandom_range(0, 59) == 0) begin
                lines_v_i = 1; lines_i = 5'($urandom_range(0, 31));
            end
            start_i      = playing_o ? ($urandom_range(0, 63) == 0) : ($urandom_range(0, 7) == 0);
            btn_left_i   = ($urandom_range(0, 11) == 0);
            btn_right_i  = ($urandom_range(0, 11) == 0);
            btn_rotate_i = ($urandom_range(0, 11) == 0);
            btn_drop_i   = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 39) == 0) pause_i = ~pause_i;
            land_i = ($urandom_range(0, 3) == 0);
            lose_i = ($urandom_range(0, 39) == 0);
        end else begin
            pause_i = 0; start_i = st; lines_v_i = lv; lines_i = lval;
        end
        @(posedge clk_i);
        #1;
        model_step();
        check_value("opcode_v", opcode_v_o, m_fire);
        if (m_fire) check_value("opcode", opcode_o, m_op);
        check_value("playing", playing_o, m_run);
        check_value("game_over", game_over_o, m_over);
        check_value("lines_total", lines_total_o, m_total);
    endtask

    initial begin
        bit seen;
        reset_n_i = 0; pause_i = 0; pl_cnt = 0; pl_op = eNop;
        clear_inputs();
        model_reset();
        repeat (3) @(negedge clk_i);
        check_value("rst_opcode_v", opcode_v_o, 1'b0);
        check_value("rst_opcode", opcode_o, eNop);
        check_value("rst_lines", lines_total_o, 16'h0000);
        check_value("rst_playing", playing_o, 1'b0);
        check_value("rst_game_over", game_over_o, 1'b0);
        reset_n_i = 1;

        for (int i = 0; i < 15000; i++) run_cycle(1, 0, 0, 5'd0);

        // Asynchronous reset while a valid is on the wire.
        seen = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            run_cycle(1, 0, 0, 5'd0);
            if (opcode_v_o) seen = 1;
        end
        check_value("wait_valid", seen, 1'b1);
        #2 reset_n_i = 0;
        #1;
        check_value("async_rst_valid", opcode_v_o, 1'b0);
        check_value("async_rst_playing", playing_o, 1'b0);
        check_value("async_rst_lines", lines_total_o, 16'h0000);
        model_reset();
        pl_cnt = 0;
        clear_inputs();
        repeat (2) @(negedge clk_i);
        reset_n_i = 1;

        // Saturation: 2114 x 31 = 0xFFFE, then +3 clips, then stays clipped.
        for (int i = 0; i < 2114; i++) run_cycle(0, 0, 1, 5'd31);
        check_value("sat_preload", lines_total_o, 16'hFFFE);
        run_cycle(0, 0, 1, 5'd3);
        check_value("sat_clip", lines_total_o, 16'hFFFF);
        run_cycle(0, 0, 1, 5'd31);
        check_value("sat_hold", lines_total_o, 16'hFFFF);
        run_cycle(0, 1, 0, 5'd0);
        check_value("start_clears", lines_total_o, 16'h0000);
        check_value("start_new", opcode_o, eNew);

        for (int i = 0; i < 100; i++) run_cycle(1, 0, 0, 5'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level play controller that drives the game plate's opcode interface.
- Turns player button pulses and an internal gravity timer into a legal opcode stream: New, MoveLeft, MoveRight, MoveDown, Rotate, Commit, Check.
- Sits between the input debouncer and the game plate; tracks cleared-line totals and game-over.
- Issues one opcode at a time and never overlaps plate operations.

Parameters:
- height_p, 32, plate height in rows; sets the line-count input width.
- gravity_period_p, 50000000, clock cycles between automatic MoveDown requests.
- gap_p, 2, idle cycles after done_i before the next issue; covers the plate's return to fetch, including the check-then-lost-then-fetch path.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- start_i  in  1  pulse; starts a game from IDLE or GAMEOVER
- pause_i  in  1  level; freezes gravity and new issues
- btn_left_i / btn_right_i / btn_rotate_i / btn_drop_i  in  1 each  single-cycle request pulses
- opcode_o  out  opcode_e  opcode to plate
- opcode_v_o  out  1  one-cycle opcode valid
- done_i  in  1  plate operation complete
- land_i  in  1  current tile cannot move down (down move-availability bit inverted)
- lose_i  in  1  plate lose flag
- lines_i  in  $clog2(height_p)  lines cleared by the last Check
- lines_v_i  in  1  lines_i valid, one cycle
- lines_total_o  out  16  cumulative cleared lines, saturating at 16'hFFFF
- playing_o  out  1  state not IDLE/GAMEOVER
- game_over_o  out  1  state == GAMEOVER

Behaviour:
- Reset (async assert, sync deassert on clk_i):
  - state = IDLE; opcode_v_o = 0; opcode_o = eNop.
  - lines_total_o = 0; all pending flags = 0; gravity counter = 0; gap counter = 0.
- States: IDLE, ISSUE, WAIT, GAP, PLAY, GAMEOVER.
- IDLE / GAMEOVER:
  - start_i clears lines_total_o and pending flags, then enters ISSUE with op = eNew.
  - Button pulses are ignored in these states.
- PLAY:
  - Gravity counter increments each cycle when !pause_i. At gravity_period_p-1 it wraps to 0 and sets pend_grav.
  - Button pulses set sticky pend_left/pend_right/pend_rot/pend_drop in any playing state, including while pause_i is high.
  - When !pause_i and any flag is set, pick by priority drop > grav > rot > left > right, clear only that flag, and go to ISSUE.
  - grav and drop map to eMoveDown; rot to eRotate; left/right to eMoveLeft/eMoveRight.
- ISSUE:
  - Drive opcode_o = op and opcode_v_o = 1 for exactly one cycle; go to WAIT.
  - For eMoveDown, latch land_q = land_i in this cycle.
- WAIT:
  - opcode_o holds; opcode_v_o = 0. Stay until done_i, then go to GAP with gap counter = 0.
  - No timeout.
- GAP: count gap_p cycles. On exit, pick the next step in this order:
  - lose_i == 1 -> GAMEOVER.
  - last op eNew -> PLAY.
  - last op eMoveDown with land_q == 1 -> ISSUE eCommit.
  - last op eMoveDown, land_q == 0, from drop -> set pend_drop again and go to PLAY, so a hard drop repeats until landing.
  - last op eCommit -> ISSUE eCheck.
  - last op eCheck -> ISSUE eNew.
  - otherwise -> PLAY.
- lines_v_i: lines_total_o += lines_i, saturating. Accepted in any state; lines_v_i arriving with no Check outstanding is still counted.
- Drop landing: pend_drop is cleared when the landing commit issues. pend_grav set during commit/check/new is held and serviced in the next PLAY.
- Gravity counter resets to 0 whenever eNew issues.
- Simultaneous start_i and a button in GAMEOVER: start wins; the button is dropped.
- reset_n_i low mid-operation forces IDLE immediately and opcode_v_o = 0 asynchronously; the plate is reset by the same reset tree.
- opcode_v_o is never asserted outside ISSUE; never two valids without an intervening done_i.

Test Plan:
- Reset, then start_i -> exactly one eNew valid pulse; done_i 2 cycles later -> PLAY after gap_p=2 cycles; opcode_v_o low thereafter with no buttons.
- gravity_period_p=8, no buttons, land_i=0 -> eMoveDown valid every 8 cycles of PLAY time, plus WAIT/GAP cycles which do not count; the counter continues only in PLAY.
- btn_left_i and btn_rotate_i pulsed the same cycle -> eRotate issued first, then eMoveLeft after its done_i + gap.
- btn_drop_i, with land_i=0 for 3 downs then 1 -> 4 eMoveDown, then eCommit, eCheck, eNew in order; lines_v_i with lines_i=2 -> lines_total_o=2.
- lines_total_o preloaded to 16'hFFFE via repeated checks, lines_i=3 -> 16'hFFFF.
- lose_i=1 during GAP after eMoveDown -> GAMEOVER, game_over_o=1, no further valids; start_i -> lines_total_o=0 and eNew issued.
